// File: rtl/term_encoder.sv
// term_encoder: converts N signed operands to non-adjacent form and streams at most
// one signed power-of-two term per lane per beat, lowest exponent first.

module term_encoder_chk #(
  parameter int N = 16
) (
  input logic         clk,
  input logic         rst,
  input logic         out_valid,
  input logic         out_ready,
  input logic [N-1:0] in_applied,
  input logic [3*N-1:0] t,
  input logic [N-1:0] s,
  input logic         out_last
);

  a_idle_quiet: assert property (@(posedge clk) disable iff (rst)
    !out_valid |-> (in_applied == {N{1'b0}}));

  a_sign_masked: assert property (@(posedge clk) disable iff (rst)
    (s & ~in_applied) == {N{1'b0}});

  a_stall_hold: assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |=> (out_valid && $stable({in_applied, t, s, out_last})));

endmodule

module term_encoder #(
  parameter int N = 16,
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W*N-1:0] values,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-1:0]   in_applied,
  output logic [3*N-1:0] t,
  output logic [N-1:0]   s,
  output logic           out_last
);

  localparam int RW = W + 1;
  localparam int SW = RW + 5;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] EMIT = 1'b1;

  logic [0:0]     state_r;
  logic [0:0]     nxt_state_s;
  logic           out_valid_r;
  logic           out_last_r;
  logic [N-1:0]   applied_r;
  logic [N-1:0]   sign_r;
  logic [3*N-1:0] t_r;
  logic [RW-1:0]  res_r [N];

  logic           load_s;
  logic           adv_s;
  logic           cap_s;
  logic           clr_s;
  logic [SW-1:0]  step_s [N];
  logic [N-1:0]   nxt_applied_s;
  logic [N-1:0]   nxt_sign_s;
  logic [3*N-1:0] nxt_t_s;
  logic           nxt_last_s;

  // One NAF digit of r: {applied, sign, exponent[2:0], residual after the step}.
  // The term's sign follows the bit above the lowest set bit, which keeps digits non-adjacent.
  function automatic logic [SW-1:0] digit_step(input logic [RW-1:0] r);
    logic [3:0]    k;
    logic [RW:0]   rx;
    logic [RW-1:0] pw;
    logic          up;
    logic [SW-1:0] res;
    k = 4'd0;
    for (int i = RW - 1; i >= 0; i--) begin
      k = r[i] ? 4'(i) : k;
    end
    rx = {r[RW-1], r};
    up = rx[k + 4'd1];
    pw = {{(RW-1){1'b0}}, 1'b1} << k;
    if (r == {RW{1'b0}}) begin
      res = {SW{1'b0}};
    end else begin
      res = {1'b1, up, k[2:0], (up ? (r + pw) : (r - pw))};
    end
    return res;
  endfunction

  assign in_ready = (state_r == IDLE) || (out_valid_r && out_last_r && out_ready);
  assign load_s   = in_valid && in_ready;
  assign adv_s    = (state_r == EMIT) && out_ready;
  assign cap_s    = load_s || (adv_s && !out_last_r);
  assign clr_s    = adv_s && out_last_r && !load_s;

  // Per-lane digit step taken on the incoming operand at load, otherwise on the held residual.
  always_comb begin
    nxt_applied_s = {N{1'b0}};
    nxt_sign_s    = {N{1'b0}};
    nxt_t_s       = {(3*N){1'b0}};
    nxt_last_s    = 1'b1;
    for (int i = 0; i < N; i++) begin
      step_s[i] = digit_step(load_s ? {values[W*i+W-1], values[W*i +: W]} : res_r[i]);
      nxt_applied_s[i]    = step_s[i][SW-1];
      nxt_sign_s[i]       = step_s[i][SW-2];
      nxt_t_s[3*i +: 3]   = step_s[i][SW-3:RW];
      nxt_last_s          = nxt_last_s && (step_s[i][RW-1:0] == {RW{1'b0}});
    end
  end

  // Next-state selection; a load during the final beat keeps the encoder in EMIT.
  always_comb begin
    nxt_state_s = state_r;
    case (state_r)
      IDLE:    nxt_state_s = load_s ? EMIT : IDLE;
      EMIT:    nxt_state_s = (out_ready && out_last_r && !load_s) ? IDLE : EMIT;
      default: nxt_state_s = IDLE;
    endcase
  end

  // State, output beat and residual registers; everything holds while a beat is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      applied_r   <= {N{1'b0}};
      sign_r      <= {N{1'b0}};
      t_r         <= {(3*N){1'b0}};
      for (int i = 0; i < N; i++) begin
        res_r[i] <= {RW{1'b0}};
      end
    end else begin
      state_r     <= nxt_state_s;
      out_valid_r <= (nxt_state_s == EMIT);
      if (cap_s) begin
        applied_r  <= nxt_applied_s;
        sign_r     <= nxt_sign_s;
        t_r        <= nxt_t_s;
        out_last_r <= nxt_last_s;
        for (int i = 0; i < N; i++) begin
          res_r[i] <= step_s[i][RW-1:0];
        end
      end else if (clr_s) begin
        applied_r  <= {N{1'b0}};
        sign_r     <= {N{1'b0}};
        t_r        <= {(3*N){1'b0}};
        out_last_r <= 1'b0;
      end
    end
  end

  assign out_valid  = out_valid_r;
  assign out_last   = out_last_r;
  assign in_applied = applied_r;
  assign t          = t_r;
  assign s          = sign_r;

  term_encoder_chk #(.N(N)) u_chk (
    .clk        (clk),
    .rst        (rst),
    .out_valid  (out_valid_r),
    .out_ready  (out_ready),
    .in_applied (applied_r),
    .t          (t_r),
    .s          (sign_r),
    .out_last   (out_last_r)
  );

endmodule

// File: tb/tb_term_encoder.sv
// Bench for term_encoder: directed table on lane 0, hand-built corner sequences,
// and random vectors checked against an arithmetic NAF model.
module tb_term_encoder;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] values;
  logic         out_valid;
  logic         out_ready;
  logic [15:0]  in_applied;
  logic [47:0]  t;
  logic [15:0]  s;
  logic         out_last;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  term_encoder #(.N(16), .W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .values     (values),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .in_applied (in_applied),
    .t          (t),
    .s          (s),
    .out_last   (out_last)
  );

  typedef struct {
    logic [7:0]  v;
    int          nb;
    logic [11:0] exps;
    logic [3:0]  sgns;
  } vec_t;

  vec_t tab [9];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  task automatic check_beat(input string name, input logic ev, input logic el,
                            input logic [15:0] ea, input logic [47:0] et, input logic [15:0] es);
    chk(name, {14'd0, out_valid, out_last, in_applied, t, s}, {14'd0, ev, el, ea, et, es});
  endtask

  task automatic load(input logic [127:0] v);
    int w;
    w = 0;
    values   = v;
    in_valid = 1'b1;
    #1;
    while (!in_ready && w < 50) begin
      cyc();
      w++;
    end
    chk("load_timeout", {95'd0, (w >= 50)}, 96'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  te;
    logic        se;
    logic        ap;
    logic [47:0] et;
    logic [15:0] ea;
    logic [15:0] es;
    logic [15:0] badmask;
    int          vals [16];
    int          ex [16][6];
    int          sg [16][6];
    int          cnt [16];
    int          sum [16];
    int          corner [6];
    int          n, e, nb, stall, p;

    corner = '{127, -128, -1, 85, -85, 1};
    tab[0] = '{8'h7F, 2, {3'd0, 3'd0, 3'd7, 3'd0}, 4'b0001};
    tab[1] = '{8'h80, 1, {3'd0, 3'd0, 3'd0, 3'd7}, 4'b0001};
    tab[2] = '{8'hFF, 1, {3'd0, 3'd0, 3'd0, 3'd0}, 4'b0001};
    tab[3] = '{8'h55, 4, {3'd6, 3'd4, 3'd2, 3'd0}, 4'b0000};
    tab[4] = '{8'h03, 2, {3'd0, 3'd0, 3'd2, 3'd0}, 4'b0001};
    tab[5] = '{8'hFD, 2, {3'd0, 3'd0, 3'd2, 3'd0}, 4'b0010};
    tab[6] = '{8'h00, 1, {3'd0, 3'd0, 3'd0, 3'd0}, 4'b0000};
    tab[7] = '{8'h40, 1, {3'd0, 3'd0, 3'd0, 3'd6}, 4'b0000};
    tab[8] = '{8'h01, 1, {3'd0, 3'd0, 3'd0, 3'd0}, 4'b0000};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    values    = 128'd0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_beat("reset_state", 1'b0, 1'b0, 16'd0, 48'd0, 16'd0);
    chk("reset_in_ready", {95'd0, in_ready}, 96'd1);

    // Directed table on lane 0.
    for (int k = 0; k < 9; k++) begin
      out_ready = 1'b1;
      load({120'd0, tab[k].v});
      for (int b = 0; b < tab[k].nb; b++) begin
        te = tab[k].exps[3*b +: 3];
        se = tab[k].sgns[b];
        ap = (tab[k].v != 8'd0);
        check_beat($sformatf("tab%0d_beat%0d", k, b), 1'b1, (b == tab[k].nb - 1),
                   {15'd0, ap}, {45'd0, te}, {15'd0, se});
        cyc();
      end
      chk($sformatf("tab%0d_idle", k), {95'd0, out_valid}, 96'd0);
    end

    // 85 on every lane: exponents 0,2,4,6 on all lanes.
    load({16{8'h55}});
    for (int b = 0; b < 4; b++) begin
      te = 3'(2 * b);
      et = {16{te}};
      check_beat($sformatf("all85_beat%0d", b), 1'b1, (b == 3), 16'hFFFF, et, 16'd0);
      cyc();
    end
    chk("all85_idle", {95'd0, out_valid}, 96'd0);

    // All-zero vector.
    load(128'd0);
    check_beat("zero_beat", 1'b1, 1'b1, 16'd0, 48'd0, 16'd0);
    cyc();
    chk("zero_idle", {95'd0, out_valid}, 96'd0);

    // Backpressure on lane 3.
    out_ready = 1'b0;
    load({96'd0, 8'h7F, 24'd0});
    for (int k = 0; k < 5; k++) begin
      check_beat($sformatf("bp_hold%0d", k), 1'b1, 1'b0, 16'h0008, 48'd0, 16'h0008);
      chk("bp_in_ready", {95'd0, in_ready}, 96'd0);
      cyc();
    end
    out_ready = 1'b1;
    check_beat("bp_beat1", 1'b1, 1'b0, 16'h0008, 48'd0, 16'h0008);
    cyc();
    check_beat("bp_beat2", 1'b1, 1'b1, 16'h0008, {36'd0, 3'd7, 9'd0}, 16'd0);
    cyc();
    chk("bp_idle", {95'd0, out_valid}, 96'd0);

    // Back-to-back: 3 loaded during the last beat of 127.
    load({120'd0, 8'h7F});
    check_beat("b2b_a1", 1'b1, 1'b0, 16'd1, 48'd0, 16'd1);
    cyc();
    check_beat("b2b_a2", 1'b1, 1'b1, 16'd1, 48'd7, 16'd0);
    values   = {120'd0, 8'h03};
    in_valid = 1'b1;
    #1;
    chk("b2b_in_ready", {95'd0, in_ready}, 96'd1);
    cyc();
    in_valid = 1'b0;
    check_beat("b2b_c1", 1'b1, 1'b0, 16'd1, 48'd0, 16'd1);
    cyc();
    check_beat("b2b_c2", 1'b1, 1'b1, 16'd1, 48'd2, 16'd0);
    cyc();
    chk("b2b_idle", {95'd0, out_valid}, 96'd0);

    // Reset during beat 2 of 85.
    load({16{8'h55}});
    check_beat("rst_mid_b1", 1'b1, 1'b0, 16'hFFFF, 48'd0, 16'd0);
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    check_beat("rst_mid_clear", 1'b0, 1'b0, 16'd0, 48'd0, 16'd0);
    chk("rst_mid_in_ready", {95'd0, in_ready}, 96'd1);
    load({120'd0, 8'hFF});
    check_beat("rst_after", 1'b1, 1'b1, 16'd1, 48'd0, 16'd1);
    cyc();

    // Random vectors against the arithmetic NAF model.
    for (int v = 0; v < 40; v++) begin
      for (int i = 0; i < 16; i++) begin
        case ($urandom_range(0, 3))
          0:       vals[i] = 0;
          1:       vals[i] = corner[$urandom_range(0, 5)];
          default: vals[i] = int'($urandom_range(0, 255)) - 128;
        endcase
        values[8*i +: 8] = 8'(vals[i]);
        n = vals[i];
        e = 0;
        cnt[i] = 0;
        sum[i] = 0;
        while (n != 0) begin
          if ((n & 3) == 1) begin
            ex[i][cnt[i]] = e; sg[i][cnt[i]] = 0; cnt[i]++; n = n - 1;
          end else if ((n & 3) == 3) begin
            ex[i][cnt[i]] = e; sg[i][cnt[i]] = 1; cnt[i]++; n = n + 1;
          end
          n = n >>> 1;
          e++;
        end
      end
      nb = 1;
      for (int i = 0; i < 16; i++) nb = (cnt[i] > nb) ? cnt[i] : nb;
      out_ready = 1'b1;
      load(values);
      for (int b = 0; b < nb; b++) begin
        ea = 16'd0; es = 16'd0; et = 48'd0;
        for (int i = 0; i < 16; i++) begin
          if (b < cnt[i]) begin
            ea[i] = 1'b1;
            es[i] = sg[i][b][0];
            et[3*i +: 3] = 3'(ex[i][b]);
          end
        end
        stall = int'($urandom_range(0, 2));
        for (int k = 0; k < stall; k++) begin
          out_ready = 1'b0;
          check_beat($sformatf("rnd%0d_stall_b%0d", v, b), 1'b1, (b == nb - 1), ea, et, es);
          cyc();
        end
        out_ready = 1'b1;
        check_beat($sformatf("rnd%0d_beat%0d", v, b), 1'b1, (b == nb - 1), ea, et, es);
        for (int i = 0; i < 16; i++) begin
          if (in_applied[i]) begin
            p = 1 << t[3*i +: 3];
            sum[i] = s[i] ? (sum[i] - p) : (sum[i] + p);
          end
        end
        cyc();
      end
      badmask = 16'd0;
      for (int i = 0; i < 16; i++) badmask[i] = (sum[i] != vals[i]);
      chk($sformatf("rnd%0d_sum", v), {80'd0, badmask}, 96'd0);
      chk($sformatf("rnd%0d_idle", v), {95'd0, out_valid}, 96'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
